uart_fifo_ctrl: RTL and testbench

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

---
 rtl/uart_fifo_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// UART with TX/RX byte FIFOs behind a four-register bus (DATA, STATUS, BAUD, CTRL).
// Define UART_PARITY_EN to add the CTRL-programmable parity bit to both engines.
module uart_fifo_ctrl #(
   parameter int CLKS_PER_BIT_RST = 4,
   parameter int TX_DEPTH         = 8,
   parameter int RX_DEPTH         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  addr_i,
   input  logic [31:0] write_data,
   input  logic        write_en,
   input  logic        i_uart_sel,
   output logic [31:0] read_data,
   output logic        uart_tx,
   input  logic        uart_rx
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic        wr_acc, rd_acc;
   logic [15:0] baud, div_eff;
   logic [1:0]  ctrl;
   logic        ovr, ferr, perr, ovr_set, ferr_set, perr_set, sticky_clr;
   logic        unused_wdata;

   assign wr_acc       = i_uart_sel & write_en;
   assign rd_acc       = i_uart_sel & ~write_en;
   assign sticky_clr   = wr_acc && (addr_i == 2'd1);
   assign unused_wdata = ^write_data[31:16];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          baud <= 16'(CLKS_PER_BIT_RST);
      else if (wr_acc && addr_i == 2'd2)   baud <= write_data[15:0];
   end
   assign div_eff = (baud < 16'd2) ? 16'd2 : baud;

`ifdef UART_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          ctrl <= 2'b00;
      else if (wr_acc && addr_i == 2'd3)   ctrl <= write_data[1:0];
   end
`else
   assign ctrl = 2'b00;
`endif

   // Set wins over a same-cycle clear so no error event is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
         perr <= 1'b0;
      end else begin
         ovr  <= (ovr  & ~(sticky_clr & write_data[4])) | ovr_set;
         ferr <= (ferr & ~(sticky_clr & write_data[5])) | ferr_set;
         perr <= (perr & ~(sticky_clr & write_data[6])) | perr_set;
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wp, tx_rp;
   logic         tx_empty, tx_full, tx_push, tx_pop;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
   assign tx_push  = wr_acc && (addr_i == 2'd0) && !tx_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= write_data[7:0];
   end

   // ---------------- TX engine ----------------
   state_t      tx_state, tx_next;
   logic [15:0] tx_cnt, tx_div;
   logic [2:0]  tx_idx;
   logic [7:0]  tx_shreg;
   logic        tx_bit, tx_bit_end, tx_busy;
`ifdef UART_PARITY_EN
   logic        tx_par_en, tx_par_odd;
`endif

   assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
   assign tx_busy    = (tx_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= S_IDLE;
      else        tx_state <= tx_next;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         S_IDLE:  if (!tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
         S_START: if (tx_bit_end) tx_next = S_DATA;
`ifdef UART_PARITY_EN
         S_DATA:   if (tx_bit_end && tx_idx == 3'd7) tx_next = tx_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (tx_bit_end) tx_next = S_STOP;
`else
         S_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = S_STOP;
`endif
         S_STOP: begin
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (tx_bit_end) begin
               if (!tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
               else           tx_next = S_IDLE;
            end
         end
         default: tx_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx_bit = 1'b1;
      case (tx_state)
         S_START:  tx_bit = 1'b0;
         S_DATA:   tx_bit = tx_shreg[tx_idx];
`ifdef UART_PARITY_EN
         S_PARITY: tx_bit = ^tx_shreg ^ tx_par_odd;
`endif
         default:  tx_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx  <= 1'b1;
         tx_cnt   <= '0;
         tx_div   <= 16'd2;
         tx_idx   <= '0;
         tx_shreg <= '0;
`ifdef UART_PARITY_EN
         tx_par_en  <= 1'b0;
         tx_par_odd <= 1'b0;
`endif
      end else begin
         uart_tx <= tx_bit;
         if (tx_pop) begin
            tx_shreg <= tx_mem[tx_rp[TAW-1:0]];
            tx_div   <= div_eff;
            tx_cnt   <= '0;
            tx_idx   <= '0;
`ifdef UART_PARITY_EN
            tx_par_en  <= ctrl[0];
            tx_par_odd <= ctrl[1];
`endif
         end else if (tx_state != S_IDLE) begin
            if (tx_bit_end) begin
               tx_cnt <= '0;
               if (tx_state == S_DATA) tx_idx <= tx_idx + 3'd1;
            end else begin
               tx_cnt <= tx_cnt + 16'd1;
            end
         end
      end
   end

   // ---------------- RX engine ----------------
   logic        rx_s1, rx_s2, rx_d;
   state_t      rx_state, rx_next;
   logic [15:0] rx_cnt, rx_div;
   logic [2:0]  rx_idx;
   logic [7:0]  rx_shreg;
   logic        rx_bit_end, rx_half_hit, rx_done, par_bad, rx_push, rx_pop;
   logic        rx_empty, rx_full;
`ifdef UART_PARITY_EN
   logic        rx_par_en, rx_par_odd, rx_par_bit;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);
   assign rx_half_hit = (rx_cnt == (rx_div >> 1) - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= S_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_d && !rx_s2) rx_next = S_START;
         S_START: if (rx_half_hit)    rx_next = rx_s2 ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
         S_DATA:   if (rx_bit_end && rx_idx == 3'd7) rx_next = rx_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (rx_bit_end) rx_next = S_STOP;
`else
         S_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = S_STOP;
`endif
         S_STOP:  if (rx_bit_end) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      par_bad = 1'b0;
`ifdef UART_PARITY_EN
      par_bad = rx_par_en && (rx_par_bit != (^rx_shreg ^ rx_par_odd));
`endif
      rx_done  = (rx_state == S_STOP) && rx_bit_end;
      ferr_set = rx_done && !rx_s2;
      perr_set = rx_done && rx_s2 && par_bad;
      rx_push  = rx_done && rx_s2 && !par_bad && !rx_full;
      ovr_set  = rx_done && rx_s2 && !par_bad && rx_full;
   end

   // Divisor and parity mode are re-captured every idle cycle, so they freeze at frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt   <= '0;
         rx_div   <= 16'd2;
         rx_idx   <= '0;
         rx_shreg <= '0;
`ifdef UART_PARITY_EN
         rx_par_en  <= 1'b0;
         rx_par_odd <= 1'b0;
         rx_par_bit <= 1'b0;
`endif
      end else if (rx_state == S_IDLE) begin
         rx_cnt <= '0;
         rx_idx <= '0;
         rx_div <= div_eff;
`ifdef UART_PARITY_EN
         rx_par_en  <= ctrl[0];
         rx_par_odd <= ctrl[1];
`endif
      end else if (rx_state == S_START) begin
         rx_cnt <= rx_half_hit ? 16'd0 : rx_cnt + 16'd1;
      end else if (rx_bit_end) begin
         rx_cnt <= '0;
         if (rx_state == S_DATA) begin
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            rx_idx   <= rx_idx + 3'd1;
         end
`ifdef UART_PARITY_EN
         if (rx_state == S_PARITY) rx_par_bit <= rx_s2;
`endif
      end else begin
         rx_cnt <= rx_cnt + 16'd1;
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wp, rx_rp, rx_count;

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
   assign rx_pop   = rd_acc && (addr_i == 2'd0) && !rx_empty;
   assign rx_count = rx_wp - rx_rp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_shreg;
   end

   always_comb begin
      read_data = 32'h0;
      case (addr_i)
         2'd0:    read_data = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rp[RAW-1:0]]};
         2'd1:    read_data = {16'h0, 8'(rx_count), 1'b0, perr, ferr, ovr,
                               tx_empty, tx_full, ~rx_empty, tx_busy};
         2'd2:    read_data = {16'h0, baud};
         default: read_data = {30'h0, ctrl};
      endcase
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: bus reads and serial TX frames are checked by
// monitors against expectations queued by the directed stimulus.
module tb_uart_fifo_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  addr_i;
   logic [31:0] write_data;
   logic        write_en;
   logic        i_uart_sel;
   logic [31:0] read_data;
   logic        uart_tx;
   logic        uart_rx;

   uart_fifo_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr_i     (addr_i),
      .write_data (write_data),
      .write_en   (write_en),
      .i_uart_sel (i_uart_sel),
      .read_data  (read_data),
      .uart_tx    (uart_tx),
      .uart_rx    (uart_rx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   logic [11:0] tx_q[$];
   int          tx_starts[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          bit_clks = 4;
   int          nbits    = 10;
   logic        abort_tx = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      addr_i = a; write_data = d; write_en = 1'b1; i_uart_sel = 1'b1;
      @(posedge clk); #1;
      i_uart_sel = 1'b0; write_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
      rd_exp_t e;
      e.exp = exp;
      e.name = name;
      rd_q.push_back(e);
      @(posedge clk); #1;
      addr_i = a; write_en = 1'b0; i_uart_sel = 1'b1;
      @(posedge clk); #1;
      i_uart_sel = 1'b0;
   endtask

   task automatic rx_bit(input logic v);
      uart_rx = v;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop, input logic use_par, input logic par);
      @(posedge clk); #1;
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      if (use_par) rx_bit(par);
      rx_bit(stop);
      uart_rx = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   // Read monitor: every read access is compared with the oldest queued expectation.
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (i_uart_sel && !write_en) begin
            check("rd_expected", (rd_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               check(e.name, read_data, e.exp);
            end
         end
      end
   end

   // TX monitor: samples every clock of a frame; each bit must hold for bit_clks clocks.
   initial begin
      logic [11:0] bits;
      logic [11:0] exp;
      logic        first;
      logic        stable;
      forever begin
         @(negedge clk);
         if (rst_n && uart_tx == 1'b0) begin
            tx_starts.push_back(cyc);
            bits   = '0;
            stable = 1'b1;
            first  = 1'b0;
            for (int b = 0; b < nbits; b++) begin
               for (int c = 0; c < bit_clks; c++) begin
                  if (!(b == 0 && c == 0)) @(negedge clk);
                  if (c == 0) first = uart_tx;
                  else if (uart_tx != first) stable = 1'b0;
               end
               bits[b] = first;
            end
            if (!abort_tx) begin
               check("tx_frame_expected", (tx_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
               if (tx_q.size() != 0) begin
                  exp = tx_q.pop_front();
                  check("tx_frame", {20'h0, bits}, {20'h0, exp});
                  check("tx_bit_len", {31'h0, stable}, 32'd1);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; i_uart_sel = 1'b0; write_en = 1'b0; addr_i = 2'd0;
      write_data = 32'h0; uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_idle", {31'h0, uart_tx}, 32'd1);
      rst_n = 1'b1;

      bus_read(2'd1, 32'h0000_0008, "rst_status");
      bus_read(2'd2, 32'h0000_0004, "rst_baud");
      bus_read(2'd3, 32'h0000_0000, "rst_ctrl");
      bus_read(2'd0, 32'h0000_0000, "rst_data_empty");

      // Single frame 0xA5: latency to start bit and busy flag.
      tx_q.push_back({2'b00, 1'b1, 8'hA5, 1'b0});
      bus_write(2'd0, 32'hA5);
      @(negedge clk); check("tx_lat_n0", {31'h0, uart_tx}, 32'd1);
      @(negedge clk); check("tx_lat_n1", {31'h0, uart_tx}, 32'd1);
      @(negedge clk); check("tx_lat_n2", {31'h0, uart_tx}, 32'd0);
      bus_read(2'd1, 32'h0000_0009, "busy_mid_frame");
      repeat (45) @(posedge clk);
      bus_read(2'd1, 32'h0000_0008, "idle_after_frame");

      // BAUD=0 reads back raw but runs at the 2-clock minimum.
      bus_write(2'd2, 32'h0);
      bus_read(2'd2, 32'h0, "baud_raw_zero");
      bit_clks = 2;
      tx_q.push_back({2'b00, 1'b1, 8'h5A, 1'b0});
      bus_write(2'd0, 32'h5A);
      repeat (30) @(posedge clk);
      bus_write(2'd2, 32'h4);
      bit_clks = 4;

      // Nine queued bytes fit (first is popped at once); a tenth is dropped.
      tx_starts.delete();
      for (int i = 1; i <= 9; i++) begin
         tx_q.push_back({2'b00, 1'b1, 8'(i), 1'b0});
         bus_write(2'd0, 32'(i));
      end
      bus_write(2'd0, 32'hFF);
      bus_read(2'd1, 32'h0000_0005, "tx_full_status");
      repeat (380) @(posedge clk);
      check("b2b_frames", tx_starts.size(), 32'd9);
      for (int i = 1; i < tx_starts.size(); i++)
         check("b2b_gap", tx_starts[i] - tx_starts[i-1], 32'd40);
      check("tx_q_drained", tx_q.size(), 32'd0);

      // Single RX byte.
      rx_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      bus_read(2'd1, 32'h0000_010A, "rx_avail_status");
      bus_read(2'd0, 32'h0000_003C, "rx_data");
      bus_read(2'd1, 32'h0000_0008, "rx_empty_status");

      // Overrun: nine frames into an eight-entry FIFO.
      for (int i = 0; i < 9; i++) rx_frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0);
      bus_read(2'd1, 32'h0000_081A, "ovr_status");
      bus_write(2'd1, 32'h10);
      bus_read(2'd1, 32'h0000_080A, "ovr_cleared");
      for (int i = 0; i < 8; i++) bus_read(2'd0, 32'h11 + 32'(i), "rx_fifo_order");
      bus_read(2'd1, 32'h0000_0008, "rx_drained");

      // False start and framing error.
      @(posedge clk); #1; uart_rx = 1'b0;
      @(posedge clk); #1; uart_rx = 1'b1;
      repeat (50) @(posedge clk);
      bus_read(2'd1, 32'h0000_0008, "glitch_no_byte");
      rx_frame(8'h55, 1'b0, 1'b0, 1'b0);
      bus_read(2'd1, 32'h0000_0028, "ferr_set");
      bus_write(2'd1, 32'h20);
      bus_read(2'd1, 32'h0000_0008, "ferr_clr");

`ifdef UART_PARITY_EN
      bus_write(2'd3, 32'h3);
      bus_read(2'd3, 32'h3, "ctrl_rw");
      nbits = 11;
      tx_q.push_back({1'b0, 1'b1, 1'b0, 8'h07, 1'b0});
      bus_write(2'd0, 32'h07);
      repeat (55) @(posedge clk);
      rx_frame(8'h07, 1'b1, 1'b1, 1'b1);
      bus_read(2'd1, 32'h0000_0048, "perr_set");
      bus_write(2'd1, 32'h40);
      bus_read(2'd1, 32'h0000_0008, "perr_clr");
      bus_write(2'd3, 32'h0);
      nbits = 10;
`else
      bus_write(2'd3, 32'h3);
      bus_read(2'd3, 32'h0, "ctrl_ignored");
`endif

      // Reset in the middle of a frame aborts it and reloads BAUD.
      bus_write(2'd2, 32'h6);
      abort_tx = 1'b1;
      bus_write(2'd0, 32'h00);
      repeat (10) @(posedge clk);
      #3;
      check("pre_abort_tx_low", {31'h0, uart_tx}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_abort_tx", {31'h0, uart_tx}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_read(2'd2, 32'h0000_0004, "rst_baud_reload");
      bus_read(2'd1, 32'h0000_0008, "rst_status_clean");
      repeat (60) @(posedge clk);
      abort_tx = 1'b0;

      repeat (5) @(posedge clk);
      check("rd_q_drained", rd_q.size(), 32'd0);
      check("tx_q_final", tx_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
